// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - in-order instruction prefetch queue with imem credit tracking and redirect flush
module if_prefetch_queue #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_valid,
    output logic [31:0]     fetch_instr,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] fetch_pcplus4,
    input  logic            fetch_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0]     NOP      = 32'h0000_0013;
    localparam logic [CW-1:0]   ONE      = CW'(1);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]   MAXOUT_C = CW'(MAX_OUTSTANDING);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [XLEN-1:0] WORD     = XLEN'(4);

    logic [XLEN-1:0] reqPc;
    logic [XLEN-1:0] respPc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   dropCnt;
    logic [AW-1:0]   wrPtr;
    logic [AW-1:0]   rdPtr;
    logic [XLEN-1:0] pcMem [DEPTH];
    logic [31:0]     instrMem [DEPTH];

    logic [XLEN-1:0] redirectTarget;
    logic [CW:0]     budget;
    logic            rspAccept;
    logic            grant;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] headPc;

    assign redirectTarget = {redirect_pc[XLEN-1:2], 2'b00};
    assign budget         = {1'b0, count} + {1'b0, outstanding};

    // A response with nothing outstanding is a leftover from before reset and is ignored.
    assign rspAccept = imem_rvalid && (outstanding != '0);
    assign push      = rspAccept && !redirect && (dropCnt == '0);
    assign pop       = fetch_valid && fetch_ready && !redirect;

    // Requests are only issued when every possible response already has a FIFO slot.
    assign imem_req  = !reset && !redirect && (dropCnt == '0) &&
                       (outstanding < MAXOUT_C) && (budget < {1'b0, DEPTH_C});
    assign imem_addr = reqPc;
    assign grant     = imem_req && imem_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reqPc  <= RESET_PC;
            respPc <= RESET_PC;
        end else if (redirect) begin
            reqPc  <= redirectTarget;
            respPc <= redirectTarget;
        end else begin
            if (grant) reqPc  <= reqPc + WORD;
            if (push)  respPc <= respPc + WORD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({grant, rspAccept})
                2'b10:   outstanding <= outstanding + ONE;
                2'b01:   outstanding <= outstanding - ONE;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Everything still in flight at a redirect belongs to the old path and must be discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dropCnt <= '0;
        end else if (redirect) begin
            dropCnt <= rspAccept ? (outstanding - ONE) : outstanding;
        end else if (rspAccept && (dropCnt != '0)) begin
            dropCnt <= dropCnt - ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (redirect) begin
            count <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_ONE;
            if (pop)  rdPtr <= rdPtr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[wrPtr]    <= respPc;
            instrMem[wrPtr] <= imem_rdata;
        end
    end

    assign headPc        = pcMem[rdPtr];
    assign fetch_valid   = (count != '0);
    assign fetch_instr   = fetch_valid ? instrMem[rdPtr] : NOP;
    assign fetch_pc      = fetch_valid ? headPc : '0;
    assign fetch_pcplus4 = fetch_valid ? (headPc + WORD) : '0;

    stray_response: assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && (outstanding == '0)))
        else $warning("imem_rvalid with no outstanding request ignored");

    no_overflow: assert property (@(posedge clk) disable iff (reset)
        push |-> (count < DEPTH_C))
        else $error("push into full prefetch queue");

    credit_bound: assert property (@(posedge clk) disable iff (reset)
        (budget <= {1'b0, DEPTH_C}) && (outstanding <= MAXOUT_C))
        else $error("prefetch credit exceeded");

    addr_stable: assert property (@(posedge clk) disable iff (reset)
        (imem_req && !imem_gnt) |=> $stable(imem_addr))
        else $error("imem_addr changed while request pending");

    aligned_redirect: assert property (@(posedge clk) disable iff (reset)
        redirect |-> (redirect_pc[1:0] == 2'b00))
        else $warning("misaligned redirect_pc forced to word boundary");
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb/tb_if_prefetch_queue.sv - randomized scoreboard bench for if_prefetch_queue
module tb_if_prefetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pcplus4;
    logic        fetch_ready = 1'b0;

    if_prefetch_queue #(.XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
        .fetch_pcplus4(fetch_pcplus4), .fetch_ready(fetch_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; bit stale; bit orphan; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    pend_t       pending[$];
    exp_t        expQ[$];
    logic [31:0] popLog[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] expReqPc = '0;
    int          latMin = 1, latMax = 1, gntMode = 0, readyMode = 1, respRandom = 0;
    bit          redirNext = 0;
    logic [31:0] redirTarget = '0;
    int          popCnt = 0, firstGrantCyc = 0, firstValidCyc = 0;
    bit          sawGrant = 0, sawValid = 0;
    bit          prevReqWait = 0;
    logic [31:0] prevAddr = '0;
    int          reqWait = 0;

    function automatic logic [31:0] memFn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chkPop(input string name, input int idx, input logic [31:0] exp);
        chk(name, (idx < popLog.size()) ? popLog[idx] : 32'hDEAD_BEEF, exp);
    endtask

    // Monitor: compares whatever decode consumes against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (fetch_valid && !sawValid) begin
                sawValid = 1;
                firstValidCyc = cyc;
            end
            if (!fetch_valid) begin
                chk("idle_instr", fetch_instr, NOP);
                chk("idle_pc", fetch_pc, 32'h0);
                chk("idle_pc4", fetch_pcplus4, 32'h0);
            end else if (expQ.size() == 0) begin
                chk("spurious_valid", {31'b0, fetch_valid}, 32'h0);
            end else if (fetch_ready && !redirect) begin
                chk("pop_pc", fetch_pc, expQ[0].pc);
                chk("pop_instr", fetch_instr, expQ[0].instr);
                chk("pop_pc4", fetch_pcplus4, expQ[0].pc + 32'd4);
                popLog.push_back(fetch_pc);
                popCnt++;
                void'(expQ.pop_front());
            end else begin
                chk("head_hold", fetch_pc, expQ[0].pc);
            end
        end
    end

    task automatic step();
        pend_t p;
        bit delivered;
        bit grant;
        bit orphanPending;
        @(posedge clk);
        #1;
        cyc++;
        orphanPending = 0;
        foreach (pending[i]) if (pending[i].orphan) orphanPending = 1;
        delivered = (pending.size() > 0) && (pending[0].due <= cyc) &&
                    (respRandom == 0 || $urandom_range(3) != 0);
        imem_rvalid = delivered;
        imem_rdata  = delivered ? memFn(pending[0].addr) : $urandom();
        case (gntMode)
            0:       imem_gnt = 1'b1;
            1:       imem_gnt = $urandom_range(1) != 0;
            2:       imem_gnt = (reqWait >= 3);
            default: imem_gnt = 1'b0;
        endcase
        if (orphanPending) imem_gnt = 1'b0;
        fetch_ready = (readyMode == 0) ? 1'b0 : (readyMode == 1) ? 1'b1 : ($urandom_range(3) != 0);
        redirect    = redirNext;
        redirect_pc = redirTarget;
        redirNext   = 0;
        #5;
        if (redirect) chk("req_on_redirect", {31'b0, imem_req}, 32'h0);
        if (prevReqWait && imem_req) chk("addr_stable", imem_addr, prevAddr);
        if (delivered) begin
            p = pending.pop_front();
            if (!p.stale && !redirect) expQ.push_back('{pc: p.addr, instr: memFn(p.addr)});
        end
        grant = imem_req && imem_gnt;
        if (grant) begin
            chk("grant_addr", imem_addr, expReqPc);
            expReqPc = expReqPc + 32'd4;
            p.addr = imem_addr;
            p.due = cyc + latMin + int'($urandom_range(latMax - latMin));
            p.stale = 0;
            p.orphan = 0;
            pending.push_back(p);
            chk("outstanding_le_max", {31'b0, pending.size() <= MAXO}, 32'h1);
            if (!sawGrant) begin
                sawGrant = 1;
                firstGrantCyc = cyc;
            end
        end
        if (redirect) begin
            foreach (pending[i]) pending[i].stale = 1;
            expQ.delete();
            expReqPc = {redirect_pc[31:2], 2'b00};
        end
        prevReqWait = imem_req && !imem_gnt;
        prevAddr = imem_addr;
        reqWait = (imem_req && !imem_gnt) ? reqWait + 1 : 0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        redirect = 1'b0;
        fetch_ready = 1'b0;
        #1;
        chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", fetch_instr, NOP);
        chk("rst_pc", fetch_pc, 32'h0);
        chk("rst_pc4", fetch_pcplus4, 32'h0);
        foreach (pending[i]) begin
            pending[i].orphan = 1;
            pending[i].stale = 1;
        end
        expQ.delete();
        expReqPc = '0;
        reqWait = 0;
        prevReqWait = 0;
        redirNext = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic setMode(input int g, input int lmin, input int lmax, input int r, input int rr);
        gntMode = g;
        latMin = lmin;
        latMax = lmax;
        readyMode = r;
        respRandom = rr;
    endtask

    task automatic drain();
        int n;
        setMode(3, 1, 1, 1, 0);
        n = 0;
        while ((pending.size() != 0 || expQ.size() != 0) && n < 80) begin
            step();
            n++;
        end
        step();
        chk("drain_empty", 32'(expQ.size() + pending.size()), 32'h0);
        chk("drain_idle", {31'b0, fetch_valid}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        doReset();

        setMode(0, 1, 1, 1, 0);
        popCnt = 0;
        sawGrant = 0;
        sawValid = 0;
        repeat (20) step();
        chk("t1_latency", 32'(firstValidCyc - firstGrantCyc), 32'd2);
        chk("t1_stream", 32'(popCnt), 32'd18);

        doReset();
        setMode(0, 1, 1, 0, 0);
        repeat (10) step();
        chk("t2_req_off", {31'b0, imem_req}, 32'h0);
        chk("t2_full_valid", {31'b0, fetch_valid}, 32'h1);
        chk("t2_head", fetch_pc, 32'h0);
        chk("t2_next_addr", imem_addr, 32'h10);
        popLog.delete();
        readyMode = 1;
        repeat (12) step();
        for (int i = 0; i < 4; i++) chkPop("t2_order", i, 32'(4 * i));

        doReset();
        setMode(0, 3, 3, 1, 0);
        n = 0;
        while (!(pending.size() == 2 && pending[0].addr == 32'h8) && n < 30) begin
            step();
            n++;
        end
        chk("t3_setup", {31'b0, pending.size() == 2 && pending[0].addr == 32'h8}, 32'h1);
        popLog.delete();
        redirNext = 1;
        redirTarget = 32'h100;
        repeat (15) step();
        chkPop("t3_first", 0, 32'h100);
        chkPop("t3_second", 1, 32'h104);

        setMode(0, 2, 2, 1, 0);
        n = 0;
        while (!(pending.size() == 2 && pending[0].due == cyc + 1 && !pending[0].stale && !pending[1].stale) && n < 30) begin
            step();
            n++;
        end
        chk("t4_setup", {31'b0, pending.size() == 2 && pending[0].due == cyc + 1}, 32'h1);
        popLog.delete();
        redirNext = 1;
        redirTarget = 32'h200;
        repeat (15) step();
        chkPop("t4_first", 0, 32'h200);
        chkPop("t4_second", 1, 32'h204);

        setMode(2, 5, 5, 2, 0);
        repeat (60) step();

        setMode(0, 1, 1, 1, 0);
        popLog.delete();
        redirNext = 1;
        redirTarget = 32'hFFFF_FFF8;
        repeat (10) step();
        chkPop("wrap_0", 0, 32'hFFFF_FFF8);
        chkPop("wrap_1", 1, 32'hFFFF_FFFC);
        chkPop("wrap_2", 2, 32'h0);

        popLog.delete();
        redirNext = 1;
        redirTarget = 32'h303;
        repeat (8) step();
        chkPop("misaligned", 0, 32'h300);

        setMode(1, 1, 4, 2, 1);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) begin
                redirNext = 1;
                redirTarget = $urandom() & 32'hFFFF_FFFC;
            end
            step();
        end
        drain();

        setMode(0, 4, 4, 0, 0);
        n = 0;
        while (!(pending.size() == 2 && expQ.size() >= 1) && n < 40) begin
            step();
            n++;
        end
        chk("t6_setup", {31'b0, pending.size() == 2 && expQ.size() >= 1}, 32'h1);
        doReset();
        readyMode = 1;
        n = 0;
        while (pending.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("t6_orphans_gone", 32'(pending.size()), 32'h0);
        chk("t6_idle", {31'b0, fetch_valid}, 32'h0);
        chk("t6_restart_addr", imem_addr, 32'h0);
        popLog.delete();
        repeat (15) step();
        chkPop("t6_first", 0, 32'h0);
        chkPop("t6_second", 1, 32'h4);

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
